tree_sequencer: RTL and testbench
=================================

TREE_SEQUENCER -- requirements
Module: tree_sequencer

Interface
REQ-001 Parameters (name, default, meaning):
- FEATURES, 3, features per node.
- COEFF_BIT_DEPTH, 4, coefficient width.
- BIAS_BIT_DEPTH, 10, bias width.
- TREE_DEPTH, 3, maximum decision levels.
- CHANNEL_COUNT, 16, independent trees.
REQ-002 Derived values: NODES = 2^TREE_DEPTH-1; W = 2+FEATURES+(FEATURES-1)*COEFF_BIT_DEPTH+BIAS_BIT_DEPTH.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  job request.
- start_channel  in  clog2(CHANNEL_COUNT)  job channel.
- busy  out  1  job in progress.
- mem_addr  out  clog2(NODES*CHANNEL_COUNT)  node word address.
- mem_data  in  W  node word, synchronous read, 1-cycle latency.
- load_bias  out  1  datapath strobe.
- add  out  1  datapath strobe.
- mult  out  1  datapath strobe.
- coeff  out  COEFF_BIT_DEPTH  current coefficient.
- is_one  out  1  current feature has unit coefficient.
- bias  out  BIAS_BIT_DEPTH  node bias.
- child_direction  in  1  datapath decision, 1 = right.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed.
- out_channel  out  clog2(CHANNEL_COUNT)  result channel.
- level  out  clog2(TREE_DEPTH+1)  decisions taken.
- path  out  TREE_DEPTH  direction taken at each depth.
REQ-004 mem_data layout, MSB first:
- Child flags: bit W-1 = left child present, bit W-2 = right child present.
- FEATURES-bit one-hot unit position; MSB = feature 0.
- FEATURES-1 coefficients; first coefficient in the most significant field.
- Bias in the LSBs.

Function
REQ-005 States: IDLE, FETCH, EVAL, DECIDE, DONE.
REQ-006 mem_addr SHALL equal channel*NODES+node and be stable from FETCH through DECIDE.
REQ-007 IDLE with start=1 and start_channel<CHANNEL_COUNT SHALL:
- latch the channel;
- set node=0, depth=0, path=0;
- go to FETCH and assert busy.
REQ-008 start with start_channel>=CHANNEL_COUNT SHALL be ignored.
REQ-009 FETCH SHALL last exactly 1 cycle, then go to EVAL.
REQ-010 EVAL SHALL last FEATURES cycles, k=0..FEATURES-1, with:
- add=1;
- load_bias=(k==0);
- is_one = one-hot bit k;
- coeff = next unused coefficient, or 0 when is_one;
- mult = ~(is_one | coeff==0).
REQ-011 The coefficient index SHALL advance only on EVAL cycles with is_one=0.
REQ-012 bias SHALL be driven from mem_data throughout EVAL.
REQ-013 Strobes SHALL be 0 outside EVAL.
REQ-014 DECIDE (1 cycle) SHALL sample child_direction (dir) and set path[depth]<=dir.
REQ-015 In DECIDE, if the flag for dir is set and depth+1<TREE_DEPTH: node<=2*node+1+dir, depth++, go to FETCH.
REQ-016 Otherwise DECIDE SHALL set level<=depth+1 and go to DONE.
REQ-017 DONE SHALL assert out_valid and hold out_channel, level and path stable until out_ready=1.
REQ-018 In DONE with out_ready=1:
- if start is also valid, accept the new job in the same cycle (go to FETCH);
- else go to IDLE and deassert busy.
REQ-019 start SHALL be ignored in FETCH, EVAL and DECIDE, and in DONE while out_ready=0.
REQ-020 Latency: out_valid first asserts L*(FEATURES+2)+1 cycles after the start-accept cycle, where L = final level.
REQ-021 busy SHALL be 1 in every non-IDLE state.

Reset
REQ-022 reset=1 SHALL immediately, without a clock edge:
- force IDLE;
- clear busy, out_valid, load_bias, add, mult, is_one, coeff, bias, level, path, out_channel, mem_addr;
- clear internal node, depth and coefficient index.
REQ-023 Reset asserted mid-job SHALL abort the job with no out_valid.
REQ-024 The first start after reset release SHALL be honoured.

Verification
REQ-025 FEATURES=3, TREE_DEPTH=3, ch 4, all flags 11, dirs 1,0,1 -> mem_addr 28,30,33; level=3, path=3'b101; out_valid at cycle 16 after accept.
REQ-026 Root word flags 00, dir=1 -> level=1, path=3'b001; out_valid at cycle 6 after accept.
REQ-027 Root one-hot 010, coeffs {2,0}; EVAL cycles:
- k=0: load_bias=1, add=1, mult=1, coeff=2;
- k=1: is_one=1, mult=0, coeff=0;
- k=2: coeff=0, mult=0, load_bias=0.
REQ-028 out_ready=0 for 10 cycles with start pulses -> outputs frozen, starts ignored; then out_ready=1 with start -> new job accepted that cycle, busy stays 1.
REQ-029 reset asserted in the 2nd EVAL cycle -> all outputs 0 before the next edge; next job re-fetches node 0.
REQ-030 start_channel=CHANNEL_COUNT in IDLE -> busy stays 0 and mem_addr stays 0.

Source files
------------

// File: rtl/tree_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tree_sequencer
// Brief   : Walks per-channel decision trees, streaming node coefficients to
//           an external datapath and reporting the decision path taken.
// Rev     : 1.0
// ============================================================================
module tree_sequencer #(
  parameter  int FEATURES        = 3,
  parameter  int COEFF_BIT_DEPTH = 4,
  parameter  int BIAS_BIT_DEPTH  = 10,
  parameter  int TREE_DEPTH      = 3,
  parameter  int CHANNEL_COUNT   = 16,
  localparam int NODES   = 2**TREE_DEPTH - 1,
  localparam int W       = 2 + FEATURES + (FEATURES-1)*COEFF_BIT_DEPTH + BIAS_BIT_DEPTH,
  localparam int CH_W    = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
  localparam int ADDR_W  = (NODES*CHANNEL_COUNT > 1) ? $clog2(NODES*CHANNEL_COUNT) : 1,
  localparam int LEVEL_W = $clog2(TREE_DEPTH+1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [CH_W-1:0]            start_channel,
  output logic                       busy,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [W-1:0]               mem_data,
  output logic                       load_bias,
  output logic                       add,
  output logic                       mult,
  output logic [COEFF_BIT_DEPTH-1:0] coeff,
  output logic                       is_one,
  output logic [BIAS_BIT_DEPTH-1:0]  bias,
  input  logic                       child_direction,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CH_W-1:0]            out_channel,
  output logic [LEVEL_W-1:0]         level,
  output logic [TREE_DEPTH-1:0]      path
);

  localparam int NODE_W  = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int DEPTH_W = (TREE_DEPTH > 1) ? $clog2(TREE_DEPTH) : 1;
  localparam int K_W     = (FEATURES > 1) ? $clog2(FEATURES) : 1;
  localparam int CIDX_W  = $clog2(FEATURES+1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_EVAL   = 3'd2;
  localparam logic [2:0] S_DECIDE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]                r_state, w_next;
  logic [CH_W-1:0]           r_channel;
  logic [NODE_W-1:0]         r_node;
  logic [DEPTH_W-1:0]        r_depth;
  logic [TREE_DEPTH-1:0]     r_path;
  logic [LEVEL_W-1:0]        r_level;
  logic [K_W-1:0]            r_k;
  logic [CIDX_W-1:0]         r_cidx;

  logic                       w_start_ok, w_flag, w_descend, w_is_one;
  logic [COEFF_BIT_DEPTH-1:0] w_coeff_sel;
  logic [2**K_W-1:0]          w_onehot_rev;
  logic [COEFF_BIT_DEPTH-1:0] w_coeff_tab [2**CIDX_W];

  // Unit-position bits reordered so index k addresses feature k; tables padded to a power of two.
  genvar gi;
  generate
    for (gi = 0; gi < 2**K_W; gi++) begin : g_onehot
      if (gi < FEATURES) begin : g_bit
        assign w_onehot_rev[gi] = mem_data[W-3-gi];
      end else begin : g_pad
        assign w_onehot_rev[gi] = 1'b0;
      end
    end
    for (gi = 0; gi < 2**CIDX_W; gi++) begin : g_coeff
      if (gi < FEATURES-1) begin : g_field
        assign w_coeff_tab[gi] =
          mem_data[BIAS_BIT_DEPTH + (FEATURES-2-gi)*COEFF_BIT_DEPTH +: COEFF_BIT_DEPTH];
      end else begin : g_pad
        assign w_coeff_tab[gi] = '0;
      end
    end
  endgenerate

  assign w_start_ok  = start && ({1'b0, start_channel} < (CH_W+1)'(CHANNEL_COUNT));
  assign w_flag      = child_direction ? mem_data[W-2] : mem_data[W-1];
  assign w_descend   = w_flag && (r_depth != DEPTH_W'(TREE_DEPTH-1));
  assign w_is_one    = w_onehot_rev[r_k];
  assign w_coeff_sel = w_is_one ? '0 : w_coeff_tab[r_cidx];

  assign mem_addr    = ADDR_W'(r_channel) * ADDR_W'(NODES) + ADDR_W'(r_node);
  assign out_channel = r_channel;
  assign level       = r_level;
  assign path        = r_path;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start_ok) w_next = S_FETCH;
      S_FETCH:  w_next = S_EVAL;
      S_EVAL:   if (r_k == K_W'(FEATURES-1)) w_next = S_DECIDE;
      S_DECIDE: w_next = w_descend ? S_FETCH : S_DONE;
      S_DONE:   if (out_ready) w_next = w_start_ok ? S_FETCH : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    out_valid = (r_state == S_DONE);
    load_bias = 1'b0;
    add       = 1'b0;
    mult      = 1'b0;
    is_one    = 1'b0;
    coeff     = '0;
    bias      = '0;
    if (r_state == S_EVAL) begin
      add       = 1'b1;
      load_bias = (r_k == '0);
      is_one    = w_is_one;
      coeff     = w_coeff_sel;
      mult      = ~(w_is_one | (w_coeff_sel == '0));
      bias      = mem_data[BIAS_BIT_DEPTH-1:0];
    end
  end

  // Job context; a new job may also be launched directly from DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_channel <= '0;
      r_node    <= '0;
      r_depth   <= '0;
      r_path    <= '0;
      r_level   <= '0;
      r_k       <= '0;
      r_cidx    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok && (r_state == S_IDLE || out_ready)) begin
            r_channel <= start_channel;
            r_node    <= '0;
            r_depth   <= '0;
            r_path    <= '0;
          end
        end
        S_FETCH: begin
          r_k    <= '0;
          r_cidx <= '0;
        end
        S_EVAL: begin
          r_k <= r_k + K_W'(1);
          if (!w_is_one) r_cidx <= r_cidx + CIDX_W'(1);
        end
        S_DECIDE: begin
          r_path[r_depth] <= child_direction;
          if (w_descend) begin
            r_node  <= r_node * NODE_W'(2) + NODE_W'(1) + NODE_W'(child_direction);
            r_depth <= r_depth + DEPTH_W'(1);
          end else begin
            r_level <= LEVEL_W'(r_depth) + LEVEL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tree_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_tree_sequencer
// Brief   : Randomized self-checking bench for tree_sequencer.
// Rev     : 1.0
// ============================================================================
module tb_tree_sequencer;

  localparam int F     = 3;
  localparam int C     = 4;
  localparam int B     = 10;
  localparam int TD    = 3;
  localparam int CHN   = 12;
  localparam int NODES = 7;
  localparam int W     = 2 + F + (F-1)*C + B;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [3:0]    start_channel;
  logic          busy;
  logic [6:0]    mem_addr;
  logic [W-1:0]  mem_data;
  logic          load_bias, add, mult, is_one;
  logic [C-1:0]  coeff;
  logic [B-1:0]  bias;
  logic          child_direction;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_channel;
  logic [1:0]    level;
  logic [TD-1:0] path;

  logic [W-1:0]  mem [NODES*CHN];
  logic [17:0]   dp;
  int            errors = 0;
  int            checks = 0;
  int            exp_ch, exp_lvl;
  logic [2:0]    exp_path;

  tree_sequencer #(
    .FEATURES(F), .COEFF_BIT_DEPTH(C), .BIAS_BIT_DEPTH(B),
    .TREE_DEPTH(TD), .CHANNEL_COUNT(CHN)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .start_channel(start_channel),
    .busy(busy), .mem_addr(mem_addr), .mem_data(mem_data),
    .load_bias(load_bias), .add(add), .mult(mult), .coeff(coeff),
    .is_one(is_one), .bias(bias), .child_direction(child_direction),
    .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel),
    .level(level), .path(path)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    mem_data <= (int'(mem_addr) < NODES*CHN) ? mem[mem_addr] : '0;

  assign dp = {load_bias, add, mult, coeff, is_one, bias};

  function automatic logic [W-1:0] rand_word();
    logic [C-1:0] c0, c1;
    c0 = ($urandom_range(0, 3) == 0) ? 4'd0 : C'($urandom);
    c1 = ($urandom_range(0, 3) == 0) ? 4'd0 : C'($urandom);
    return {2'($urandom), 3'(1 << $urandom_range(0, F-1)), c0, c1, B'($urandom)};
  endfunction

  // Accept a job from IDLE (or DONE when ready is also given); returns in FETCH.
  task automatic accept(input int ch);
    start = 1'b1;
    start_channel = 4'(ch);
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
  endtask

  // Reference walk of one job from its first FETCH cycle to DONE.
  task automatic run_job(input int ch, input logic [2:0] dirs);
    int node = 0, depth = 0, cidx;
    bit fin = 0, one, dir, flag;
    logic [C-1:0] c;
    logic [W-1:0] word;
    logic [17:0] exp_dp;
    logic [2:0] p = 3'b000;
    while (!fin) begin
      word = mem[ch*NODES + node];
      child_direction = dirs[depth];
      checks++;
      if ({busy, out_valid, mem_addr, dp} !== {1'b1, 1'b0, 7'(ch*NODES+node), 18'd0})
        $display("FAIL fetch: got busy=%b valid=%b addr=%0d dp=%h expected addr=%0d",
                 busy, out_valid, mem_addr, dp, ch*NODES+node);
      if ({busy, out_valid, mem_addr, dp} !== {1'b1, 1'b0, 7'(ch*NODES+node), 18'd0}) errors++;
      @(negedge clk);
      cidx = 0;
      for (int k = 0; k < F; k++) begin
        one = word[W-3-k];
        c = (one || cidx >= F-1) ? 4'd0 : C'(word >> (B + (F-2-cidx)*C));
        if (!one) cidx++;
        exp_dp = {(k == 0), 1'b1, !(one || c == 0), c, one, word[B-1:0]};
        checks++;
        if ({busy, out_valid, mem_addr, dp} !== {1'b1, 1'b0, 7'(ch*NODES+node), exp_dp}) begin
          errors++;
          $display("FAIL eval k=%0d: got addr=%0d dp=%h valid=%b expected addr=%0d dp=%h",
                   k, mem_addr, dp, out_valid, ch*NODES+node, exp_dp);
        end
        @(negedge clk);
      end
      checks++;
      if ({busy, out_valid, mem_addr, dp} !== {1'b1, 1'b0, 7'(ch*NODES+node), 18'd0}) begin
        errors++;
        $display("FAIL decide: got addr=%0d dp=%h valid=%b expected addr=%0d",
                 mem_addr, dp, out_valid, ch*NODES+node);
      end
      dir = dirs[depth];
      p[depth] = dir;
      flag = dir ? word[W-2] : word[W-1];
      if (flag && depth + 1 < TD) begin
        node = 2*node + 1 + int'(dir);
        depth++;
      end else begin
        exp_lvl = depth + 1;
        fin = 1;
      end
      @(negedge clk);
    end
    exp_ch = ch;
    exp_path = p;
    checks++;
    if ({out_valid, busy, out_channel, level, path} !== {1'b1, 1'b1, 4'(ch), 2'(exp_lvl), p}) begin
      errors++;
      $display("FAIL done: got valid=%b busy=%b ch=%0d level=%0d path=%b expected ch=%0d level=%0d path=%b",
               out_valid, busy, out_channel, level, path, ch, exp_lvl, p);
    end
  endtask

  task automatic release_job();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL release: got busy=%b valid=%b expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, out_valid, dp, level, path, out_channel, mem_addr} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b valid=%b dp=%h addr=%0d expected all 0",
               busy, out_valid, dp, mem_addr);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_invalid_channel();
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start_channel = 4'(CHN + (i % 4));
      @(negedge clk);
      checks++;
      if ({busy, mem_addr} !== 8'd0) begin
        errors++;
        $display("FAIL invalid_channel: got busy=%b addr=%0d expected 0 0", busy, mem_addr);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_full_depth();
    mem[28][W-1 -: 2] = 2'b11;
    mem[30][W-1 -: 2] = 2'b11;
    mem[33][W-1 -: 2] = 2'b11;
    accept(4);
    run_job(4, 3'b101);
    release_job();
  endtask

  task automatic test_root_leaf();
    mem[7*NODES][W-1 -: 2] = 2'b00;
    accept(7);
    run_job(7, 3'b001);
    release_job();
  endtask

  task automatic test_unit_coeff();
    mem[2*NODES] = {2'b10, 3'b010, 4'd2, 4'd0, 10'h2A5};
    accept(2);
    run_job(2, 3'b000);
    release_job();
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 8; j++) begin
      int ch;
      ch = $urandom_range(0, CHN-1);
      accept(ch);
      run_job(ch, 3'($urandom));
      release_job();
    end
  endtask

  task automatic test_back_to_back();
    int ch, nc;
    ch = $urandom_range(0, CHN-1);
    nc = (ch + 5) % CHN;
    accept(ch);
    run_job(ch, 3'($urandom));
    for (int i = 0; i < 10; i++) begin
      start = 1'($urandom);
      start_channel = 4'($urandom_range(0, CHN-1));
      @(negedge clk);
      checks++;
      if ({out_valid, busy, out_channel, level, path} !== {1'b1, 1'b1, 4'(exp_ch), 2'(exp_lvl), exp_path}) begin
        errors++;
        $display("FAIL hold: got valid=%b ch=%0d level=%0d path=%b expected ch=%0d level=%0d path=%b",
                 out_valid, out_channel, level, path, exp_ch, exp_lvl, exp_path);
      end
    end
    accept(nc);
    run_job(nc, 3'($urandom));
    release_job();
  endtask

  task automatic test_reset_mid_job();
    int ch;
    ch = $urandom_range(0, CHN-1);
    mem[ch*NODES][W-1 -: 2] = 2'b11;
    accept(ch);
    child_direction = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, out_valid, dp, level, path, out_channel, mem_addr} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b valid=%b dp=%h addr=%0d expected all 0",
               busy, out_valid, dp, mem_addr);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({busy, out_valid} !== 2'b00) begin
        errors++;
        $display("FAIL reset_hold: got busy=%b valid=%b expected 0 0", busy, out_valid);
      end
    end
    reset = 1'b0;
    accept(ch);
    run_job(ch, 3'($urandom));
    release_job();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    start_channel = '0;
    out_ready = 1'b0;
    child_direction = 1'b0;
    for (int i = 0; i < NODES*CHN; i++) mem[i] = rand_word();
    @(negedge clk);
    test_reset();
    test_invalid_channel();
    test_full_depth();
    test_root_leaf();
    test_unit_coeff();
    test_random_jobs();
    test_back_to_back();
    test_reset_mid_job();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
